dco_tune_ctrl: RTL and testbench
================================

// Module: dco_tune_ctrl
// PURPOSE
//  Parametrised tuning-word controller in front of the DCO capacitor banks.
//  Runs a coarse-acquisition search, then tracking, on the DLF output word.
//  Drives thermometer-coded coarse and fine banks plus a first-order sigma-delta dither bit for the small-cap cell.
//  Sits between the DLF and the DCO; runs on the reference clock.
// PARAMETERS
//  DLF_W      16  DLF word width; unsigned, Q(DLF_W-FRAC_W).FRAC_W
//  FRAC_W     8   fractional bits of dlf_out
//  COARSE_N   8   coarse cells; coarse_cnt range 0..COARSE_N
//  FINE_N     32  fine cells; fine_cnt range 0..FINE_N
//  WIN        512 coarse in-band half-window, dlf_out LSBs
//  LOCK_CNT   4   consecutive in-band samples needed to leave COARSE
//  SETTLE_CYC 2   dlf_valid samples ignored after each coarse step
//  OOR_CNT    8   consecutive clamped TRACK samples that trigger relock
// PORTS
//  ref_clk       in  1         clock
//  rst           in  1         synchronous active-high reset
//  acq_start     in  1         pulse: (re)start acquisition
//  dlf_valid     in  1         dlf_out valid this cycle
//  dlf_out       in  DLF_W     loop-filter word
//  coarse_therm  out COARSE_N  thermometer code, (1<<coarse_cnt)-1
//  fine_therm    out FINE_N    thermometer code, (1<<fine_cnt)-1
//  dither        out 1         sigma-delta carry to small-cap cell
//  state_o       out 2         0 IDLE, 1 COARSE, 2 SETTLE, 3 TRACK
//  locked        out 1         high while in TRACK
//  oor           out 1         sticky out-of-range flag; cleared by acq_start
// BEHAVIOUR
//  Interface: one clock, ref_clk; reset rst is synchronous and active-high.
//  Reset: state IDLE, coarse_cnt=COARSE_N/2, fine_cnt=FINE_N/2, acc=0; dither=0, locked=0, oor=0.
//  All outputs registered; a dlf_valid sample affects outputs on the next edge. rst dominates all inputs.
//  acq_start in any state: next state COARSE, coarse_cnt=COARSE_N/2, fine_cnt=FINE_N/2, counters/acc/oor cleared.
//  IDLE: dlf_valid ignored; outputs hold reset values.
//  COARSE, per dlf_valid, MID=2^(DLF_W-1):
//   - dlf_out > MID+WIN: coarse_cnt+1, in-band count cleared, go SETTLE
//   - dlf_out < MID-WIN: coarse_cnt-1, in-band count cleared, go SETTLE
//   - otherwise: in-band count +1; reaching LOCK_CNT goes TRACK with acc=0
//  Coarse saturation: a step at 0 or COARSE_N leaves coarse_cnt unchanged, sets oor, and still goes SETTLE.
//  SETTLE: counts dlf_valid samples; after SETTLE_CYC samples returns to COARSE (samples discarded).
//  TRACK, per dlf_valid: IW=DLF_W-FRAC_W, ip=dlf_out[DLF_W-1:FRAC_W].
//   - fine_cnt = clamp(ip - (2^(IW-1) - FINE_N/2), 0, FINE_N), signed arithmetic, IW+2 bits
//   - frac register = dlf_out[FRAC_W-1:0]
//   - a clamped sample increments the OOR counter; an unclamped sample clears it
//   - OOR counter reaching OOR_CNT: set oor, go COARSE (coarse/fine counts kept)
//  Dither (TRACK, every ref_clk): {dither, acc} = acc + frac over FRAC_W+1 bits; wraps; dither=0 outside TRACK.
//  coarse_cnt is frozen in TRACK; fine_cnt is frozen outside TRACK.
// CONFIGURATION
//  DCO_DITHER_EN defined: sigma-delta accumulator as above.
//  DCO_DITHER_EN undefined: no acc/frac logic; dither tied 0; fine_cnt uses ip+dlf_out[FRAC_W-1] (round half up) before clamp.
// TESTING (defaults; MID=32768)
//  1. rst high 3 cycles -> state_o=0, coarse_therm=8'h0F, fine_therm=32'h0000FFFF, dither=0, locked=0.
//  2. acq_start, then dlf_out=40000 valid each cycle -> coarse 5,6,7,8 with 2 SETTLE samples between steps; at 8 sets oor, coarse_therm=8'hFF.
//  3. acq_start, dlf_out=32768 x4 -> state_o=3, locked=1 on 5th edge; coarse_therm=8'h0F.
//  4. TRACK, dlf_out=16'h7480 (ip=116) -> fine_cnt=4, fine_therm=32'hF; with DCO_DITHER_EN dither toggles 1,0,1,0; without: fine_cnt=5, dither=0.
//  5. TRACK, dlf_out=16'hFF00 x8 -> fine_therm all ones, oor=1, state_o=1 after 8th sample.
//  6. acq_start and rst asserted same cycle in TRACK -> reset values; acq_start alone in SETTLE -> COARSE, counts to midscale.

Source files
------------

// File: rtl/dco_tune_ctrl_if.sv
// rtl/dco_tune_ctrl_if.sv - DLF-side input bundle for dco_tune_ctrl
interface dco_tune_ctrl_if #(
  parameter int DLF_W = 16
) ();
  logic             acq_start;
  logic             dlf_valid;
  logic [DLF_W-1:0] dlf_out;

  modport master (output acq_start, output dlf_valid, output dlf_out);
  modport slave  (input  acq_start, input  dlf_valid, input  dlf_out);
endinterface

// File: rtl/dco_tune_ctrl.sv
// rtl/dco_tune_ctrl.sv - DCO tuning-word controller: coarse search, fine tracking, dither
// Define DCO_DITHER_EN for the sigma-delta dither path; otherwise fine_cnt rounds half up.
module dco_tune_ctrl #(
  parameter int DLF_W      = 16,
  parameter int FRAC_W     = 8,
  parameter int COARSE_N   = 8,
  parameter int FINE_N     = 32,
  parameter int WIN        = 512,
  parameter int LOCK_CNT   = 4,
  parameter int SETTLE_CYC = 2,
  parameter int OOR_CNT    = 8
) (
  input  logic                ref_clk,
  input  logic                rst,
  dco_tune_ctrl_if.slave      dlf,
  output logic [COARSE_N-1:0] coarse_therm,
  output logic [FINE_N-1:0]   fine_therm,
  output logic                dither,
  output logic [1:0]          state_o,
  output logic                locked,
  output logic                oor
);
  localparam int IW  = DLF_W - FRAC_W;
  localparam int CW  = $clog2(COARSE_N + 1);
  localparam int FW  = $clog2(FINE_N + 1);
  localparam int IBW = $clog2(LOCK_CNT + 1);
  localparam int SW  = $clog2(SETTLE_CYC + 1);
  localparam int OW  = $clog2(OOR_CNT + 1);

  localparam logic [DLF_W:0]       HI_TH    = (DLF_W+1)'(2**(DLF_W-1) + WIN);
  localparam logic [DLF_W:0]       LO_TH    = (DLF_W+1)'(2**(DLF_W-1) - WIN);
  localparam logic [CW-1:0]        C_MID    = CW'(COARSE_N / 2);
  localparam logic [CW-1:0]        C_MAX    = CW'(COARSE_N);
  localparam logic [FW-1:0]        F_MID    = FW'(FINE_N / 2);
  localparam logic [FW-1:0]        F_MAX    = FW'(FINE_N);
  localparam logic [IBW-1:0]       LOCK_M1  = IBW'(LOCK_CNT - 1);
  localparam logic [SW-1:0]        SET_M1   = SW'(SETTLE_CYC - 1);
  localparam logic [OW-1:0]        OOR_M1   = OW'(OOR_CNT - 1);
  localparam logic signed [IW+1:0] FINE_OFS = (IW+2)'(2**(IW-1) - FINE_N/2);
  localparam logic signed [IW+1:0] FINE_LIM = (IW+2)'(FINE_N);

  typedef enum logic [1:0] {IDLE = 2'd0, COARSE = 2'd1, SETTLE = 2'd2, TRACK = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   coarse_q, coarse_d;
  logic [FW-1:0]   fine_q, fine_d;
  logic [IBW-1:0]  inb_q, inb_d;
  logic [SW-1:0]   set_q, set_d;
  logic [OW-1:0]   oorc_q, oorc_d;
  logic            oor_q, oor_d;
  logic signed [IW+1:0] fine_raw;
  logic            clamped;

`ifdef DCO_DITHER_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic              dither_q, dither_d;
`else
  logic unused_frac_bits;
  assign unused_frac_bits = ^dlf.dlf_out[FRAC_W-1:0];
`endif

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      coarse_q <= C_MID;
      fine_q   <= F_MID;
      inb_q    <= '0;
      set_q    <= '0;
      oorc_q   <= '0;
      oor_q    <= 1'b0;
`ifdef DCO_DITHER_EN
      acc_q    <= '0;
      frac_q   <= '0;
      dither_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      coarse_q <= coarse_d;
      fine_q   <= fine_d;
      inb_q    <= inb_d;
      set_q    <= set_d;
      oorc_q   <= oorc_d;
      oor_q    <= oor_d;
`ifdef DCO_DITHER_EN
      acc_q    <= acc_d;
      frac_q   <= frac_d;
      dither_q <= dither_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    coarse_d = coarse_q;
    fine_d   = fine_q;
    inb_d    = inb_q;
    set_d    = set_q;
    oorc_d   = oorc_q;
    oor_d    = oor_q;
`ifdef DCO_DITHER_EN
    acc_d    = acc_q;
    frac_d   = frac_q;
    dither_d = 1'b0;
`endif
    // Fine position relative to the DLF integer midscale; one extra bit keeps the sign.
    fine_raw = $signed({2'b00, dlf.dlf_out[DLF_W-1:FRAC_W]}) - FINE_OFS;
`ifndef DCO_DITHER_EN
    fine_raw = fine_raw + $signed({{(IW+1){1'b0}}, dlf.dlf_out[FRAC_W-1]});
`endif
    clamped = fine_raw[IW+1] || (fine_raw > FINE_LIM);

    if (dlf.acq_start) begin
      state_d  = COARSE;
      coarse_d = C_MID;
      fine_d   = F_MID;
      inb_d    = '0;
      set_d    = '0;
      oorc_d   = '0;
      oor_d    = 1'b0;
`ifdef DCO_DITHER_EN
      acc_d    = '0;
      frac_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: ;
        COARSE: if (dlf.dlf_valid) begin
          if ({1'b0, dlf.dlf_out} > HI_TH || {1'b0, dlf.dlf_out} < LO_TH) begin
            inb_d   = '0;
            set_d   = '0;
            state_d = SETTLE;
            if ({1'b0, dlf.dlf_out} > HI_TH) begin
              if (coarse_q == C_MAX) oor_d = 1'b1;
              else                   coarse_d = coarse_q + 1'b1;
            end else begin
              if (coarse_q == '0) oor_d = 1'b1;
              else                coarse_d = coarse_q - 1'b1;
            end
          end else if (inb_q == LOCK_M1) begin
            inb_d   = '0;
            oorc_d  = '0;
            state_d = TRACK;
`ifdef DCO_DITHER_EN
            acc_d   = '0;
            frac_d  = '0;
`endif
          end else begin
            inb_d = inb_q + 1'b1;
          end
        end
        SETTLE: if (dlf.dlf_valid) begin
          if (set_q == SET_M1) begin
            set_d   = '0;
            state_d = COARSE;
          end else begin
            set_d = set_q + 1'b1;
          end
        end
        TRACK: begin
`ifdef DCO_DITHER_EN
          {dither_d, acc_d} = {1'b0, acc_q} + {1'b0, frac_q};
`endif
          if (dlf.dlf_valid) begin
            if (fine_raw[IW+1])          fine_d = '0;
            else if (fine_raw > FINE_LIM) fine_d = F_MAX;
            else                          fine_d = fine_raw[FW-1:0];
`ifdef DCO_DITHER_EN
            frac_d = dlf.dlf_out[FRAC_W-1:0];
`endif
            if (!clamped) begin
              oorc_d = '0;
            end else if (oorc_q == OOR_M1) begin
              oorc_d  = '0;
              inb_d   = '0;
              oor_d   = 1'b1;
              state_d = COARSE;
`ifdef DCO_DITHER_EN
              dither_d = 1'b0;
`endif
            end else begin
              oorc_d = oorc_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    coarse_therm = '0;
    fine_therm   = '0;
    for (int i = 0; i < COARSE_N; i++) coarse_therm[i] = (i < int'(coarse_q));
    for (int i = 0; i < FINE_N; i++)   fine_therm[i]   = (i < int'(fine_q));
  end

`ifdef DCO_DITHER_EN
  assign dither = dither_q;
`else
  assign dither = 1'b0;
`endif
  assign state_o = state_q;
  assign locked  = (state_q == TRACK);
  assign oor     = oor_q;
endmodule

// File: tb/tb_dco_tune_ctrl.sv
// tb/tb_dco_tune_ctrl.sv - directed plus randomized bench for dco_tune_ctrl against an arithmetic model
module tb_dco_tune_ctrl;
  localparam int DLF_W = 16, FRAC_W = 8, COARSE_N = 8, FINE_N = 32, WIN = 512;
  localparam int LOCK_CNT = 4, SETTLE_CYC = 2, OOR_CNT = 8;
  localparam int MID = 1 << (DLF_W - 1);
  localparam int IW = DLF_W - FRAC_W;
  localparam int FINE_OFS = (1 << (IW - 1)) - FINE_N / 2;

  logic                ref_clk = 1'b0;
  logic                rst = 1'b1;
  logic [COARSE_N-1:0] coarse_therm;
  logic [FINE_N-1:0]   fine_therm;
  logic                dither, locked, oor;
  logic [1:0]          state_o;

  dco_tune_ctrl_if #(.DLF_W(DLF_W)) bus ();

  dco_tune_ctrl #(
    .DLF_W(DLF_W), .FRAC_W(FRAC_W), .COARSE_N(COARSE_N), .FINE_N(FINE_N), .WIN(WIN),
    .LOCK_CNT(LOCK_CNT), .SETTLE_CYC(SETTLE_CYC), .OOR_CNT(OOR_CNT)
  ) dut (
    .ref_clk(ref_clk), .rst(rst), .dlf(bus.slave),
    .coarse_therm(coarse_therm), .fine_therm(fine_therm), .dither(dither),
    .state_o(state_o), .locked(locked), .oor(oor)
  );

  always #5 ref_clk = ~ref_clk;

  int n_tests = 0;
  int n_fail = 0;

  // Reference model: 0 idle, 1 coarse search, 2 settle, 3 track.
  int m_state, m_coarse, m_fine, m_inb, m_set, m_oorc, m_oor, m_acc, m_frac, m_dither;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] therm(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_coarse = COARSE_N / 2; m_fine = FINE_N / 2;
    m_inb = 0; m_set = 0; m_oorc = 0; m_oor = 0; m_acc = 0; m_frac = 0; m_dither = 0;
  endtask

  task automatic model_edge(input logic r, input logic a, input logic v, input int d);
    int carry, target;
    carry = 0;
    if (r) begin
      model_reset();
      return;
    end
    if (a) begin
      model_reset();
      m_state = 1;
      return;
    end
    if (m_state == 1 && v) begin
      if (d > MID + WIN || d < MID - WIN) begin
        target = m_coarse + ((d > MID + WIN) ? 1 : -1);
        if (target < 0 || target > COARSE_N) m_oor = 1;
        else m_coarse = target;
        m_inb = 0; m_set = 0; m_state = 2;
      end else begin
        m_inb++;
        if (m_inb == LOCK_CNT) begin
          m_inb = 0; m_oorc = 0; m_acc = 0; m_frac = 0; m_state = 3;
        end
      end
    end else if (m_state == 2 && v) begin
      m_set++;
      if (m_set == SETTLE_CYC) begin
        m_set = 0; m_state = 1;
      end
    end else if (m_state == 3) begin
`ifdef DCO_DITHER_EN
      carry = (m_acc + m_frac) / (1 << FRAC_W);
      m_acc = (m_acc + m_frac) % (1 << FRAC_W);
`endif
      if (v) begin
        target = (d >> FRAC_W) - FINE_OFS;
`ifndef DCO_DITHER_EN
        target += (d >> (FRAC_W - 1)) & 1;
`endif
        m_fine = (target < 0) ? 0 : (target > FINE_N) ? FINE_N : target;
`ifdef DCO_DITHER_EN
        m_frac = d % (1 << FRAC_W);
`endif
        if (target < 0 || target > FINE_N) m_oorc++;
        else m_oorc = 0;
        if (m_oorc == OOR_CNT) begin
          m_oorc = 0; m_inb = 0; m_oor = 1; m_state = 1; carry = 0;
        end
      end
    end
    m_dither = carry;
  endtask

  task automatic compare_all(input string ph);
    check_eq({ph, ".state"},  64'(state_o),      64'(m_state));
    check_eq({ph, ".coarse"}, 64'(coarse_therm), therm(m_coarse));
    check_eq({ph, ".fine"},   64'(fine_therm),   therm(m_fine));
    check_eq({ph, ".dither"}, 64'(dither),       64'(m_dither));
    check_eq({ph, ".locked"}, 64'(locked),       64'(m_state == 3));
    check_eq({ph, ".oor"},    64'(oor),          64'(m_oor));
  endtask

  task automatic step(input string ph, input logic r, input logic a, input logic v, input int d);
    rst = r;
    bus.acq_start = a;
    bus.dlf_valid = v;
    bus.dlf_out = d[DLF_W-1:0];
    @(posedge ref_clk);
    model_edge(r, a, v, d);
    #1;
    compare_all(ph);
  endtask

  int ones;
  int d;
  logic r_r, a_r, v_r;

  initial begin
    bus.acq_start = 1'b0; bus.dlf_valid = 1'b0; bus.dlf_out = '0;
    model_reset();
    for (int i = 0; i < 3; i++) step("rst", 1, 0, 1, 40000);
    check_eq("rst.coarse_lit", 64'(coarse_therm), 64'h0F);
    check_eq("rst.fine_lit", 64'(fine_therm), 64'h0000FFFF);
    step("idle", 0, 0, 1, 40000);
    check_eq("idle.state_lit", 64'(state_o), 64'd0);

    step("up", 0, 1, 0, 0);
    for (int i = 0; i < 15; i++) step("up", 0, 0, 1, 40000);
    check_eq("up.coarse_lit", 64'(coarse_therm), 64'hFF);
    check_eq("up.oor_lit", 64'(oor), 64'd1);

    step("lock", 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("lock", 0, 0, 1, 32768);
    check_eq("lock.state_lit", 64'(state_o), 64'd3);
    check_eq("lock.coarse_lit", 64'(coarse_therm), 64'h0F);

    ones = 0;
    for (int i = 1; i <= 10; i++) begin
      step("trk", 0, 0, 1, 16'h7480);
      if (i >= 3) ones += int'(dither);
    end
`ifdef DCO_DITHER_EN
    check_eq("trk.fine_lit", 64'(fine_therm), 64'hF);
    check_eq("trk.dither_ones", 64'(ones), 64'd4);
`else
    check_eq("trk.fine_lit", 64'(fine_therm), 64'h1F);
    check_eq("trk.dither_ones", 64'(ones), 64'd0);
`endif

    for (int i = 0; i < 8; i++) step("oor", 0, 0, 1, 16'hFF00);
    check_eq("oor.fine_lit", 64'(fine_therm), 64'hFFFFFFFF);
    check_eq("oor.flag_lit", 64'(oor), 64'd1);
    check_eq("oor.state_lit", 64'(state_o), 64'd1);

    step("rstacq", 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step("rstacq", 0, 0, 1, 32768);
    step("rstacq", 1, 1, 1, 32768);
    check_eq("rstacq.state_lit", 64'(state_o), 64'd0);
    check_eq("rstacq.fine_lit", 64'(fine_therm), 64'h0000FFFF);
    step("settle", 0, 1, 0, 0);
    step("settle", 0, 0, 1, 20000);
    check_eq("settle.state_lit", 64'(state_o), 64'd2);
    step("settle", 0, 1, 0, 0);
    check_eq("settle.restart_lit", 64'(state_o), 64'd1);
    check_eq("settle.coarse_lit", 64'(coarse_therm), 64'h0F);

    for (int i = 0; i < 4000; i++) begin
      r_r = ($urandom_range(0, 299) == 0);
      a_r = ($urandom_range(0, 79) == 0);
      v_r = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 19))
        0, 1, 2:    d = $urandom_range(0, 65535);
        3, 4, 5, 6: d = MID - 3000 + $urandom_range(0, 6000);
        default:    d = MID - 600 + $urandom_range(0, 1200);
      endcase
      step("rnd", r_r, a_r, v_r, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
